// File: rtl/udp_ctrl_regbank_if.sv
// udp_ctrl_regbank_if: register access bus between the UDP server and the register bank
interface udp_ctrl_regbank_if;
  logic reg_wr_en;
  logic reg_rd_en;
  logic [7:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic reg_ack;
  modport master (output reg_wr_en, reg_rd_en, reg_addr, reg_wdata, input reg_rdata, reg_ack);
  modport slave (input reg_wr_en, reg_rd_en, reg_addr, reg_wdata, output reg_rdata, reg_ack);
endinterface

// File: rtl/udp_ctrl_regbank.sv
// udp_ctrl_regbank: control/config/status registers for the payload generator with pipelined reads
module udp_ctrl_regbank #(
  parameter logic [31:0] ID_VALUE = 32'hC0DE_0100,
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [15:0] DEFAULT_LEN = 16'd1024,
  parameter logic [15:0] MIN_LEN = 16'd8,
  parameter logic [15:0] MAX_LEN = 16'd8972,
  parameter logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF
) (
  input  logic clk,
  input  logic rst,
  udp_ctrl_regbank_if.slave bus,
  output logic gen_enable,
  output logic gen_loopback,
  output logic gen_soft_rst,
  output logic [15:0] gen_pkt_len,
  output logic [15:0] gen_ifg,
  output logic [15:0] gen_dst_port,
  input  logic gen_busy,
  input  logic tx_pkt_done,
  input  logic tx_overflow,
  input  logic crc_err
);
  logic [31:0] scratch, tx_cnt, rd_mux;
  logic [15:0] pkt_len, ifg, dst_port, err_cnt, len_clamp;
  logic [1:0] ctrl;
  logic soft_rst, ovf, crc;
  logic [RD_LATENCY-1:0] vld;
  logic [31:0] dat [RD_LATENCY];
  logic wr_ctrl, wr_status, wr_err;
  assign wr_ctrl = bus.reg_wr_en && bus.reg_addr == 8'h02;
  assign wr_status = bus.reg_wr_en && bus.reg_addr == 8'h06;
  assign wr_err = bus.reg_wr_en && bus.reg_addr == 8'h08;
  assign len_clamp = bus.reg_wdata[15:0] < MIN_LEN ? MIN_LEN :
                     bus.reg_wdata[15:0] > MAX_LEN ? MAX_LEN : bus.reg_wdata[15:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch <= '0;
      ctrl <= '0;
      pkt_len <= DEFAULT_LEN;
      ifg <= '0;
      dst_port <= 16'h1234;
      soft_rst <= 1'b0;
      ovf <= 1'b0;
      crc <= 1'b0;
      tx_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (bus.reg_wr_en) begin
        case (bus.reg_addr)
          8'h01: scratch <= bus.reg_wdata;
          8'h02: ctrl <= bus.reg_wdata[1:0];
          8'h03: pkt_len <= len_clamp;
          8'h04: ifg <= bus.reg_wdata[15:0];
          8'h05: dst_port <= bus.reg_wdata[15:0];
          default: ;
        endcase
      end
      soft_rst <= wr_ctrl && bus.reg_wdata[8];
      // a set pulse beats a same-cycle write-1-to-clear
      ovf <= tx_overflow | (ovf & ~(wr_status && bus.reg_wdata[1]));
      crc <= crc_err | (crc & ~(wr_status && bus.reg_wdata[2]));
      tx_cnt <= soft_rst ? '0 : tx_cnt + {31'd0, tx_pkt_done};
      err_cnt <= wr_err ? '0 : err_cnt + {15'd0, crc_err && err_cnt != 16'hFFFF};
    end
  end
  always_comb begin
    rd_mux = BAD_ADDR_DATA;
    case (bus.reg_addr)
      8'h00: rd_mux = ID_VALUE;
      8'h01: rd_mux = scratch;
      8'h02: rd_mux = {30'd0, ctrl};
      8'h03: rd_mux = {16'd0, pkt_len};
      8'h04: rd_mux = {16'd0, ifg};
      8'h05: rd_mux = {16'd0, dst_port};
      8'h06: rd_mux = {29'd0, crc, ovf, gen_busy};
      8'h07: rd_mux = tx_cnt;
      8'h08: rd_mux = {16'd0, err_cnt};
      default: rd_mux = BAD_ADDR_DATA;
    endcase
  end
  // data stages load only with their valid, so the last stage holds rdata between acks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= bus.reg_rd_en;
      if (bus.reg_rd_en) dat[0] <= rd_mux;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end
  assign bus.reg_ack = vld[RD_LATENCY-1];
  assign bus.reg_rdata = dat[RD_LATENCY-1];
  assign gen_enable = ctrl[0];
  assign gen_loopback = ctrl[1];
  assign gen_soft_rst = soft_rst;
  assign gen_pkt_len = pkt_len;
  assign gen_ifg = ifg;
  assign gen_dst_port = dst_port;
endmodule

// File: tb/tb_udp_ctrl_regbank.sv
// tb_udp_ctrl_regbank: table-driven register access vectors plus hand-written multi-cycle sequences
module tb_udp_ctrl_regbank;
  logic clk = 1'b0, rst = 1'b1;
  logic gen_enable, gen_loopback, gen_soft_rst;
  logic [15:0] gen_pkt_len, gen_ifg, gen_dst_port;
  logic gen_busy = 1'b0, tx_pkt_done = 1'b0, tx_overflow = 1'b0, crc_err = 1'b0;
  int n_vec = 0, n_err = 0;
  udp_ctrl_regbank_if bus();
  udp_ctrl_regbank dut (
    .clk(clk), .rst(rst), .bus(bus),
    .gen_enable(gen_enable), .gen_loopback(gen_loopback), .gen_soft_rst(gen_soft_rst),
    .gen_pkt_len(gen_pkt_len), .gen_ifg(gen_ifg), .gen_dst_port(gen_dst_port),
    .gen_busy(gen_busy), .tx_pkt_done(tx_pkt_done), .tx_overflow(tx_overflow), .crc_err(crc_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit wr;
    logic [7:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [22];
  logic [31:0] b2b_exp [4];
  logic [7:0] b2b_addr [4];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_wr_en = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_wr_en = 1'b0;
  endtask
  task automatic do_read(input logic [7:0] a, input logic [31:0] e, input logic td);
    @(negedge clk);
    bus.reg_rd_en = 1'b1; bus.reg_addr = a; tx_pkt_done = td;
    @(negedge clk);
    bus.reg_rd_en = 1'b0; tx_pkt_done = 1'b0;
    chk("ack_early", {31'd0, bus.reg_ack}, 32'd0);
    @(negedge clk);
    chk("ack", {31'd0, bus.reg_ack}, 32'd1);
    chk($sformatf("rd_%02h", a), bus.reg_rdata, e);
  endtask
  task automatic check_reset_values();
    for (int i = 0; i < 10; i++) do_read(vecs[i].addr, vecs[i].exp, 1'b0);
    chk("rst_enable", {31'd0, gen_enable}, 32'd0);
    chk("rst_loopback", {31'd0, gen_loopback}, 32'd0);
    chk("rst_pkt_len", {16'd0, gen_pkt_len}, 32'd1024);
    chk("rst_dst_port", {16'd0, gen_dst_port}, 32'h1234);
  endtask
  initial begin
    vecs[0]  = '{0, 8'h00, 32'h0, 32'hC0DE0100};
    vecs[1]  = '{0, 8'h03, 32'h0, 32'h00000400};
    vecs[2]  = '{0, 8'h05, 32'h0, 32'h00001234};
    vecs[3]  = '{0, 8'h01, 32'h0, 32'h0};
    vecs[4]  = '{0, 8'h02, 32'h0, 32'h0};
    vecs[5]  = '{0, 8'h04, 32'h0, 32'h0};
    vecs[6]  = '{0, 8'h06, 32'h0, 32'h0};
    vecs[7]  = '{0, 8'h07, 32'h0, 32'h0};
    vecs[8]  = '{0, 8'h08, 32'h0, 32'h0};
    vecs[9]  = '{0, 8'h09, 32'h0, 32'hDEADBEEF};
    vecs[10] = '{1, 8'h03, 32'd3, 32'd8};
    vecs[11] = '{1, 8'h03, 32'd20000, 32'd8972};
    vecs[12] = '{1, 8'h03, 32'd1500, 32'd1500};
    vecs[13] = '{1, 8'h03, 32'd8, 32'd8};
    vecs[14] = '{1, 8'h03, 32'd8972, 32'd8972};
    vecs[15] = '{1, 8'h03, 32'h0001_0005, 32'd8};
    vecs[16] = '{1, 8'h01, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[17] = '{1, 8'h04, 32'h12345678, 32'h00005678};
    vecs[18] = '{1, 8'h05, 32'hFFFF0050, 32'h00000050};
    vecs[19] = '{1, 8'h00, 32'h11111111, 32'hC0DE0100};
    vecs[20] = '{1, 8'h02, 32'hFFFFFEFC, 32'h0};
    vecs[21] = '{1, 8'h20, 32'h01234567, 32'hDEADBEEF};
    bus.reg_wr_en = 1'b0; bus.reg_rd_en = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, bus.reg_ack}, 32'd0);
    chk("rst_rdata", bus.reg_rdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata);
        if (vecs[i].addr == 8'h03) chk("gen_pkt_len", {16'd0, gen_pkt_len}, vecs[i].exp);
      end
      do_read(vecs[i].addr, vecs[i].exp, 1'b0);
    end
    chk("gen_ifg", {16'd0, gen_ifg}, 32'h5678);
    chk("gen_dst_port", {16'd0, gen_dst_port}, 32'h50);
    chk("soft_rst_idle", {31'd0, gen_soft_rst}, 32'd0);
    // packet counter, then soft reset with a coincident tx_pkt_done
    @(negedge clk); tx_pkt_done = 1'b1;
    repeat (3) @(negedge clk);
    tx_pkt_done = 1'b0;
    do_read(8'h07, 32'd3, 1'b0);
    @(negedge clk);
    bus.reg_wr_en = 1'b1; bus.reg_addr = 8'h02; bus.reg_wdata = 32'h103;
    @(negedge clk);
    bus.reg_wr_en = 1'b0; tx_pkt_done = 1'b1;
    chk("soft_rst_pulse", {31'd0, gen_soft_rst}, 32'd1);
    chk("gen_enable", {31'd0, gen_enable}, 32'd1);
    chk("gen_loopback", {31'd0, gen_loopback}, 32'd1);
    @(negedge clk);
    tx_pkt_done = 1'b0;
    chk("soft_rst_one_cycle", {31'd0, gen_soft_rst}, 32'd0);
    do_read(8'h07, 32'd0, 1'b0);
    do_read(8'h02, 32'd3, 1'b0);
    do_read(8'h07, 32'd0, 1'b1);
    do_read(8'h07, 32'd1, 1'b0);
    // sticky status bits
    @(negedge clk); tx_overflow = 1'b1;
    @(negedge clk); tx_overflow = 1'b0;
    do_read(8'h06, 32'h2, 1'b0);
    @(negedge clk);
    bus.reg_wr_en = 1'b1; bus.reg_addr = 8'h06; bus.reg_wdata = 32'h2; tx_overflow = 1'b1;
    @(negedge clk);
    bus.reg_wr_en = 1'b0; tx_overflow = 1'b0;
    do_read(8'h06, 32'h2, 1'b0);
    do_write(8'h06, 32'h2);
    do_read(8'h06, 32'h0, 1'b0);
    @(negedge clk); crc_err = 1'b1;
    @(negedge clk); crc_err = 1'b0;
    gen_busy = 1'b1;
    do_read(8'h06, 32'h5, 1'b0);
    gen_busy = 1'b0;
    do_read(8'h08, 32'd1, 1'b0);
    @(negedge clk);
    bus.reg_wr_en = 1'b1; bus.reg_addr = 8'h08; bus.reg_wdata = 32'h0; crc_err = 1'b1;
    @(negedge clk);
    bus.reg_wr_en = 1'b0; crc_err = 1'b0;
    do_read(8'h08, 32'd0, 1'b0);
    do_write(8'h06, 32'h4);
    do_read(8'h06, 32'h0, 1'b0);
    // error counter saturation
    @(negedge clk); crc_err = 1'b1;
    repeat (65540) @(negedge clk);
    crc_err = 1'b0;
    do_read(8'h08, 32'h0000FFFF, 1'b0);
    // four back-to-back reads
    b2b_addr = '{8'h01, 8'h09, 8'h00, 8'h07};
    b2b_exp = '{32'hA5A5A5A5, 32'hDEADBEEF, 32'hC0DE0100, 32'd1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("b2b_ack", {31'd0, bus.reg_ack}, 32'd1);
        chk($sformatf("b2b_data%0d", k - 2), bus.reg_rdata, b2b_exp[k-2]);
      end else chk("b2b_ack_early", {31'd0, bus.reg_ack}, 32'd0);
      bus.reg_rd_en = (k < 4);
      if (k < 4) bus.reg_addr = b2b_addr[k];
    end
    @(negedge clk);
    chk("b2b_ack_end", {31'd0, bus.reg_ack}, 32'd0);
    chk("b2b_hold", bus.reg_rdata, 32'd1);
    // simultaneous write and read returns the pre-write value
    @(negedge clk);
    bus.reg_wr_en = 1'b1; bus.reg_rd_en = 1'b1; bus.reg_addr = 8'h01; bus.reg_wdata = 32'h11;
    @(negedge clk);
    bus.reg_wr_en = 1'b0; bus.reg_rd_en = 1'b0;
    @(negedge clk);
    chk("wr_rd_ack", {31'd0, bus.reg_ack}, 32'd1);
    chk("wr_rd_old", bus.reg_rdata, 32'hA5A5A5A5);
    do_read(8'h01, 32'h11, 1'b0);
    // reset with two reads in flight
    @(negedge clk); bus.reg_rd_en = 1'b1; bus.reg_addr = 8'h01;
    @(negedge clk); bus.reg_addr = 8'h00;
    #2 rst = 1'b1;
    bus.reg_rd_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid_ack", {31'd0, bus.reg_ack}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_ack", {31'd0, bus.reg_ack}, 32'd0);
    end
    check_reset_values();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
